// File: rtl/csa_add_sched.sv
// Byte-serial scheduler sharing one external 8-bit carry-select adder between two requesters.
// Optional two's-complement overflow output enabled by defining CSA_SCHED_OVF_EN.
module csa_add_sched #(
   parameter int NBYTES = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                in0_valid,
   output logic                in0_ready,
   input  logic [8*NBYTES-1:0] in0_a,
   input  logic [8*NBYTES-1:0] in0_b,
   input  logic                in0_cin,
   input  logic                in1_valid,
   output logic                in1_ready,
   input  logic [8*NBYTES-1:0] in1_a,
   input  logic [8*NBYTES-1:0] in1_b,
   input  logic                in1_cin,
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic                rsp_id,
   output logic [8*NBYTES-1:0] rsp_sum,
   output logic                rsp_cout,
   output logic [7:0]          add_a,
   output logic [7:0]          add_b,
   output logic                add_cin,
   input  logic [7:0]          add_sum,
   input  logic                add_cout,
   output logic                busy
`ifdef CSA_SCHED_OVF_EN
   ,
   output logic                rsp_ovf
`endif
);

   localparam int W  = 8 * NBYTES;
   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    state_q, state_d;
   logic [IW-1:0] idx_q, idx_d;
   logic [W-1:0]  a_q, a_d;
   logic [W-1:0]  b_q, b_d;
   logic [W-1:0]  sum_q, sum_d;
   logic          carry_q, carry_d;
   logic          cout_q, cout_d;
   logic          id_q, id_d;
   logic          prio_q, prio_d;   // requester preferred when both are valid
   logic          grant0, grant1;

   // Readies are forced low while reset is asserted so they match the other reset values.
   always_comb begin
      grant0 = 1'b0;
      grant1 = 1'b0;
      if (rst_n && state_q == S_IDLE) begin
         if (in0_valid && (!in1_valid || !prio_q)) grant0 = 1'b1;
         else if (in1_valid)                       grant1 = 1'b1;
      end
   end

   assign in0_ready = grant0;
   assign in1_ready = grant1;

   always_comb begin
      // NOTE: every variable gets a default first so no path through the case infers a latch.
      state_d = state_q;
      idx_d   = idx_q;
      a_d     = a_q;
      b_d     = b_q;
      sum_d   = sum_q;
      carry_d = carry_q;
      cout_d  = cout_q;
      id_d    = id_q;
      prio_d  = prio_q;
      case (state_q)
         S_IDLE: begin
            if (grant0 || grant1) begin
               a_d     = grant1 ? in1_a : in0_a;
               b_d     = grant1 ? in1_b : in0_b;
               carry_d = grant1 ? in1_cin : in0_cin;
               id_d    = grant1;
               idx_d   = '0;
               state_d = S_RUN;
            end
         end
         S_RUN: begin
            sum_d[int'(idx_q)*8 +: 8] = add_sum;
            carry_d = add_cout;
            idx_d   = idx_q + IW'(1);
            if (idx_q == LAST_IDX) begin
               cout_d  = add_cout;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            if (rsp_ready) begin
               prio_d  = ~id_q;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         a_q     <= '0;
         b_q     <= '0;
         sum_q   <= '0;
         carry_q <= 1'b0;
         cout_q  <= 1'b0;
         id_q    <= 1'b0;
         prio_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         a_q     <= a_d;
         b_q     <= b_d;
         sum_q   <= sum_d;
         carry_q <= carry_d;
         cout_q  <= cout_d;
         id_q    <= id_d;
         prio_q  <= prio_d;
      end
   end

   // Carry into the adder comes only from carry_q, never straight from add_cout.
   assign add_a   = (state_q == S_RUN) ? a_q[int'(idx_q)*8 +: 8] : 8'h00;
   assign add_b   = (state_q == S_RUN) ? b_q[int'(idx_q)*8 +: 8] : 8'h00;
   assign add_cin = (state_q == S_RUN) ? carry_q : 1'b0;

   assign rsp_valid = (state_q == S_DONE);
   assign rsp_id    = id_q;
   assign rsp_sum   = sum_q;
   assign rsp_cout  = cout_q;
   assign busy      = (state_q != S_IDLE);

`ifdef CSA_SCHED_OVF_EN
   assign rsp_ovf = (a_q[W-1] == b_q[W-1]) && (sum_q[W-1] != a_q[W-1]);
`endif

endmodule

// File: tb/tb_csa_add_sched.sv
// Randomized self-checking bench for csa_add_sched; models the shared adder and the
// expected results with plain W-bit arithmetic and a round-robin preference bit.
module tb_csa_add_sched;

   localparam int NBYTES = 4;
   localparam int W      = 8 * NBYTES;

   logic          clk;
   logic          rst_n;
   logic          in0_valid, in0_ready, in0_cin;
   logic [W-1:0]  in0_a, in0_b;
   logic          in1_valid, in1_ready, in1_cin;
   logic [W-1:0]  in1_a, in1_b;
   logic          rsp_valid, rsp_ready, rsp_id, rsp_cout;
   logic [W-1:0]  rsp_sum;
   logic [7:0]    add_a, add_b, add_sum;
   logic          add_cin, add_cout, busy;
`ifdef CSA_SCHED_OVF_EN
   logic          rsp_ovf;
`endif

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] op_a [2];
   logic [W-1:0] op_b [2];
   bit           op_c [2];
   bit           pref;

   csa_add_sched #(.NBYTES(NBYTES)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_a     (in0_a),
      .in0_b     (in0_b),
      .in0_cin   (in0_cin),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_a     (in1_a),
      .in1_b     (in1_b),
      .in1_cin   (in1_cin),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_id    (rsp_id),
      .rsp_sum   (rsp_sum),
      .rsp_cout  (rsp_cout),
      .add_a     (add_a),
      .add_b     (add_b),
      .add_cin   (add_cin),
      .add_sum   (add_sum),
      .add_cout  (add_cout),
      .busy      (busy)
`ifdef CSA_SCHED_OVF_EN
      ,
      .rsp_ovf   (rsp_ovf)
`endif
   );

   // External shared 8-bit adder.
   assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {8'h00, add_cin};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Carry entering byte k of a W-bit add.
   function automatic bit carry_into(input logic [W-1:0] a, input logic [W-1:0] b,
                                     input bit cin, input int k);
      logic [W:0] mask, s;
      if (k == 0) return cin;
      mask = ({{W{1'b0}}, 1'b1} << (8 * k)) - 1;
      s    = ({1'b0, a} & mask) + ({1'b0, b} & mask) + (W+1)'(cin);
      return s[8*k];
   endfunction

   function automatic logic [W-1:0] rand_word();
      return W'({$urandom(), $urandom()});
   endfunction

   task automatic rand_op(input int i);
      op_a[i] = rand_word();
      op_b[i] = rand_word();
      op_c[i] = 1'($urandom_range(0, 1));
   endtask

   task automatic noise_drive();
      in0_valid = 1'($urandom_range(0, 1));
      in1_valid = 1'($urandom_range(0, 1));
      in0_a     = rand_word();
      in1_b     = rand_word();
      in0_cin   = 1'($urandom_range(0, 1));
   endtask

   task automatic do_reset();
      rst_n     = 1'b0;
      in0_valid = 1'b1;
      in1_valid = 1'b1;
      #1;
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_id", rsp_id, 0);
      check("rst_rsp_sum", rsp_sum, 0);
      check("rst_rsp_cout", rsp_cout, 0);
      check("rst_add_a", add_a, 0);
      check("rst_add_b", add_b, 0);
      check("rst_add_cin", add_cin, 0);
      check("rst_busy", busy, 0);
      check("rst_in0_ready", in0_ready, 0);
      check("rst_in1_ready", in1_ready, 0);
`ifdef CSA_SCHED_OVF_EN
      check("rst_rsp_ovf", rsp_ovf, 0);
`endif
      repeat (2) @(posedge clk);
      @(negedge clk);
      in0_valid = 1'b0;
      in1_valid = 1'b0;
      rst_n     = 1'b1;
      pref      = 1'b0;
   endtask

   // One complete operation, entered and left at a negedge with the DUT idle.
   task automatic transact(input bit v0, input bit v1, input int bp, input bit noise);
      bit           win, ec;
      logic [W-1:0] ea, eb;
      logic [W:0]   full;
      in0_valid = v0;  in0_a = op_a[0];  in0_b = op_b[0];  in0_cin = op_c[0];
      in1_valid = v1;  in1_a = op_a[1];  in1_b = op_b[1];  in1_cin = op_c[1];
      win = (v0 && v1) ? pref : !v0;
      #1;
      check("idle_busy", busy, 0);
      check("in0_ready_grant", in0_ready, (v0 && !win));
      check("in1_ready_grant", in1_ready, (v1 && win));
      ea   = op_a[win];
      eb   = op_b[win];
      ec   = op_c[win];
      full = {1'b0, ea} + {1'b0, eb} + (W+1)'(ec);
      @(posedge clk);
      for (int k = 0; k < NBYTES; k++) begin
         @(negedge clk);
         if (noise) noise_drive();
         #1;
         check("run_rsp_valid", rsp_valid, 0);
         check("run_busy", busy, 1);
         check("run_in0_ready", in0_ready, 0);
         check("run_in1_ready", in1_ready, 0);
         check("run_add_a", add_a, ea[8*k +: 8]);
         check("run_add_b", add_b, eb[8*k +: 8]);
         check("run_add_cin", add_cin, carry_into(ea, eb, ec, k));
         @(posedge clk);
      end
      for (int c = 0; c <= bp; c++) begin
         @(negedge clk);
         if (noise) noise_drive();
         rsp_ready = (c == bp);
         #1;
         check("done_rsp_valid", rsp_valid, 1);
         check("done_busy", busy, 1);
         check("done_in0_ready", in0_ready, 0);
         check("done_in1_ready", in1_ready, 0);
         check("done_add_a", add_a, 0);
         check("done_rsp_sum", rsp_sum, full[W-1:0]);
         check("done_rsp_cout", rsp_cout, full[W]);
         check("done_rsp_id", rsp_id, win);
`ifdef CSA_SCHED_OVF_EN
         check("done_rsp_ovf", rsp_ovf, (ea[W-1] == eb[W-1]) && (full[W-1] != ea[W-1]));
`endif
         @(posedge clk);
      end
      @(negedge clk);
      rsp_ready = 1'b0;
      if (noise) begin
         in0_valid = 1'b0;
         in1_valid = 1'b0;
      end
      #1;
      check("post_busy", busy, 0);
      check("post_rsp_valid", rsp_valid, 0);
      pref = !win;
   endtask

   initial begin
      rst_n = 1'b0;  rsp_ready = 1'b0;
      in0_valid = 1'b0;  in0_a = '0;  in0_b = '0;  in0_cin = 1'b0;
      in1_valid = 1'b0;  in1_a = '0;  in1_b = '0;  in1_cin = 1'b0;
      pref = 1'b0;
      rand_op(0);
      rand_op(1);
      do_reset();

      // Single op with a carry into byte 1.
      op_a[0] = W'(32'h0000_00FF);  op_b[0] = W'(32'h0000_0001);  op_c[0] = 1'b0;
      transact(1, 0, 0, 0);
      // Full ripple through every byte.
      op_a[1] = W'(32'hFFFF_FFFF);  op_b[1] = '0;  op_c[1] = 1'b1;
      transact(0, 1, 0, 0);
      // Backpressure in DONE.
      rand_op(0);
      transact(1, 0, 5, 0);

      // Both requesters valid continuously from reset.
      do_reset();
      rand_op(0);
      rand_op(1);
      for (int i = 0; i < 4; i++) begin
         transact(1, 1, 0, 0);
         rand_op(!pref);
      end

      // Reset while the third byte is on the adder.
      @(negedge clk);
      in0_valid = 1'b1;  in0_a = rand_word();  in0_b = rand_word();  in0_cin = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in0_valid = 1'b0;
      repeat (2) begin
         @(posedge clk);
         @(negedge clk);
      end
      check("mid_busy_before_rst", busy, 1);
      do_reset();
      check("mid_no_rsp", rsp_valid, 0);
      op_a[0] = W'(5);  op_b[0] = W'(7);  op_c[0] = 1'b0;
      transact(1, 0, 0, 0);

      // Signed overflow and carry-out corner cases.
      op_a[0] = W'(32'h7FFF_FFFF);  op_b[0] = W'(1);  op_c[0] = 1'b0;
      transact(1, 0, 0, 0);
      op_a[1] = W'(32'hFFFF_FFFF);  op_b[1] = W'(1);  op_c[1] = 1'b0;
      transact(0, 1, 0, 0);

      // Random traffic with input noise during RUN/DONE and random backpressure.
      for (int i = 0; i < 30; i++) begin
         bit v0, v1;
         rand_op(0);
         rand_op(1);
         v0 = 1'($urandom_range(0, 1));
         v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
         transact(v0, v1, int'($urandom_range(0, 3)), 1);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
